// File: rtl/trace_pkg.sv
// Shared constants, types and helpers for the trace line UART.
package trace_pkg;

  localparam int unsigned LINE_LEN = 24;
  localparam int unsigned IDX_W    = 5;

  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // CPU state captured when a trace line is accepted
  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] r3;
  } snap_t;

  // Uppercase ASCII hex digit for one nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_DIGIT_BASE + 8'(nib);
    return ASCII_ALPHA_BASE + 8'(nib - 4'd10);
  endfunction

endpackage

// File: rtl/trace_uart_if.sv
// CPU-side bundle for the trace UART: trigger, sampled registers and line status.
interface trace_uart_if;
  logic        trigger;
  logic [7:0]  pc;
  logic [15:0] r0;
  logic [15:0] r1;
  logic [15:0] r2;
  logic [15:0] r3;
  logic        tx;
  logic        busy;
  logic        overrun;

  modport master (output trigger, pc, r0, r1, r2, r3, input tx, busy, overrun);
  modport slave  (input trigger, pc, r0, r1, r2, r3, output tx, busy, overrun);
endinterface

// File: rtl/trace_uart_tx.sv
// 8N1 byte serializer with valid/ready intake. ready_c is also high on the
// last stop-bit cycle so consecutive bytes follow with no idle gap; tail_c
// flags the cycle before that, giving the sequencer time to present the next byte.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready_c,
  output logic       tail_c,
  output logic       tx
);

  localparam int unsigned CNT_W          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BITS_PER_FRAME = 10;
  localparam int unsigned BIT_W          = $clog2(BITS_PER_FRAME);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_TAIL = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] STOP_BIT  = BIT_W'(BITS_PER_FRAME - 1);

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [8:0]       shreg;
  logic             in_stop;

  assign in_stop = active && (bit_cnt == STOP_BIT);
  assign ready_c = !active || (in_stop && (baud_cnt == BAUD_LAST));
  assign tail_c  = in_stop && (baud_cnt == BAUD_TAIL);

  // Frame timing: start bit on intake, then data LSB-first, then stop bit
  always_ff @(posedge clock) begin
    if (reset) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      tx       <= 1'b1;
    end else if (valid && ready_c) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {1'b1, data};
      tx       <= 1'b0;
    end else if (active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == STOP_BIT) begin
          active  <= 1'b0;
          bit_cnt <= '0;
          tx      <= 1'b1;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/trace_uart.sv
// Emits one ASCII trace line "PP RRRR RRRR RRRR RRRR\r\n" per accepted trigger.
// Byte 0 is handed to the serializer on the accepting edge straight from the
// live inputs (the same values being captured), so the start bit follows at once.
module trace_uart
  import trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input logic         clock,
  input logic         reset,
  trace_uart_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  snap_t            snap, snap_nx, live_c;
  logic             busy, busy_nx;
  logic             overrun, overrun_nx;
  logic             valid_c;
  logic [7:0]       byte_c;
  logic             ready_c;
  logic             tail_c;
  logic             tx;

  assign live_c = '{pc: bus.pc, r0: bus.r0, r1: bus.r1, r2: bus.r2, r3: bus.r3};

  // Character at a given line position
  function automatic logic [7:0] line_char(input snap_t s, input logic [IDX_W-1:0] i);
    logic [7:0] c;
    c = ASCII_LF;
    case (i)
      5'd0:  c = hex_ascii(s.pc[7:4]);
      5'd1:  c = hex_ascii(s.pc[3:0]);
      5'd2, 5'd7, 5'd12, 5'd17: c = ASCII_SPACE;
      5'd3:  c = hex_ascii(s.r0[15:12]);
      5'd4:  c = hex_ascii(s.r0[11:8]);
      5'd5:  c = hex_ascii(s.r0[7:4]);
      5'd6:  c = hex_ascii(s.r0[3:0]);
      5'd8:  c = hex_ascii(s.r1[15:12]);
      5'd9:  c = hex_ascii(s.r1[11:8]);
      5'd10: c = hex_ascii(s.r1[7:4]);
      5'd11: c = hex_ascii(s.r1[3:0]);
      5'd13: c = hex_ascii(s.r2[15:12]);
      5'd14: c = hex_ascii(s.r2[11:8]);
      5'd15: c = hex_ascii(s.r2[7:4]);
      5'd16: c = hex_ascii(s.r2[3:0]);
      5'd18: c = hex_ascii(s.r3[15:12]);
      5'd19: c = hex_ascii(s.r3[11:8]);
      5'd20: c = hex_ascii(s.r3[7:4]);
      5'd21: c = hex_ascii(s.r3[3:0]);
      5'd22: c = ASCII_CR;
      default: c = ASCII_LF;
    endcase
    return c;
  endfunction

  // Sequencer state, character index, snapshot and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      snap    <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      snap    <= snap_nx;
      busy    <= busy_nx;
      overrun <= overrun_nx;
    end
  end

  // Next-state, byte selection and trigger accept/drop decisions
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    snap_nx    = snap;
    busy_nx    = busy;
    overrun_nx = overrun;
    valid_c    = 1'b0;
    byte_c     = line_char(snap, idx);
    case (state)
      IDLE: begin
        byte_c = line_char(live_c, '0);
        if (bus.trigger) begin
          valid_c  = 1'b1;
          snap_nx  = live_c;
          busy_nx  = 1'b1;
          idx_nx   = '0;
          state_nx = SEND;
        end
      end
      LOAD: begin
        valid_c = 1'b1;
        if (ready_c) state_nx = SEND;
      end
      SEND: begin
        if (idx == LAST_IDX) begin
          if (ready_c) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end
        end else if (tail_c) begin
          state_nx = LOAD;
          idx_nx   = idx + IDX_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (bus.trigger && (state != IDLE)) overrun_nx = 1'b1;
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock   (clock),
    .reset   (reset),
    .valid   (valid_c),
    .data    (byte_c),
    .ready_c (ready_c),
    .tail_c  (tail_c),
    .tx      (tx)
  );

  assign bus.tx      = tx;
  assign bus.busy    = busy;
  assign bus.overrun = overrun;

endmodule

// File: tb/tb_trace_uart.sv
// Directed and randomized bench for trace_uart with a string-level line model
// and a sample-log UART decoder.
module tb_trace_uart;

  localparam int CPB     = 4;
  localparam int LOG_LEN = 32768;
  localparam int LINE_CY = 240 * CPB;

  logic clock = 1'b0;
  logic reset;

  trace_uart_if bus ();

  trace_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int    cyc      = 0;
  int    checks   = 0;
  int    failures = 0;
  string hexdig   = "0123456789ABCDEF";
  logic  tx_log   [LOG_LEN];
  logic  busy_log [LOG_LEN];

  // Cycle counter and per-cycle output log (sampled mid-cycle)
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (cyc < LOG_LEN) begin
      tx_log[cyc]   = bus.tx;
      busy_log[cyc] = bus.busy;
    end
  end

  // Runaway guard
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 24-byte line, first character in the MSBs
  function automatic logic [191:0] model_line(input logic [7:0] pc, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] c,
                                              input logic [15:0] d);
    byte         q[$];
    logic [15:0] regs[4];
    logic [191:0] v;
    regs = '{a, b, c, d};
    q.push_back(hexdig[int'(pc) / 16]);
    q.push_back(hexdig[int'(pc) % 16]);
    for (int r = 0; r < 4; r++) begin
      q.push_back(8'h20);
      for (int dgt = 3; dgt >= 0; dgt--) q.push_back(hexdig[(int'(regs[r]) >> (4 * dgt)) % 16]);
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    v = '0;
    for (int i = 0; i < 24; i++) v[191 - 8 * i -: 8] = q[i];
    return v;
  endfunction

  // Decode a line starting at log index k+1; errs counts framing and intra-bit glitches
  task automatic decode(input int k, output logic [191:0] line, output int errs);
    errs = 0;
    line = '0;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      b = '0;
      for (int j = 0; j < 10; j++) begin
        int   base;
        logic v;
        base = k + 1 + (i * 10 + j) * CPB;
        v    = tx_log[base];
        for (int s = 1; s < CPB; s++) if (tx_log[base + s] !== v) errs++;
        if (j == 0) begin
          if (v !== 1'b0) errs++;
        end else if (j == 9) begin
          if (v !== 1'b1) errs++;
        end else begin
          b[j - 1] = v;
        end
      end
      line[191 - 8 * i -: 8] = b;
    end
  endtask

  task automatic wait_until(input int m);
    while (cyc < m) @(negedge clock);
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    @(negedge clock);
    bus.trigger = 1'b0;
  endtask

  // Trigger at the current negedge; k is the log index just before the start bit
  task automatic send_line(input logic [7:0] pc, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d, output int k);
    bus.pc = pc;
    bus.r0 = a;
    bus.r1 = b;
    bus.r2 = c;
    bus.r3 = d;
    k = cyc;
    pulse_trigger();
  endtask

  task automatic check_line(input string tag, input int k, input logic [191:0] exp);
    logic [191:0] got;
    int           errs;
    int           n;
    wait_until(k + LINE_CY + 4);
    decode(k, got, errs);
    chk({tag, "_text"}, got, exp);
    chk({tag, "_frame"}, 192'(errs), 192'(0));
    n = 0;
    while (n < 2000 && busy_log[k + 1 + n] === 1'b1) n++;
    chk({tag, "_busy_len"}, 192'(n), 192'(LINE_CY));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int          k, k2, zeros, ones;
    logic [7:0]  pc;
    logic [15:0] a, b, c, d;
    logic [39:0] wave_obs, wave_exp;
    logic        frame_a[10];

    reset       = 1'b1;
    bus.trigger = 1'b0;
    bus.pc      = '0;
    bus.r0      = '0;
    bus.r1      = '0;
    bus.r2      = '0;
    bus.r3      = '0;
    repeat (3) @(negedge clock);
    chk("reset_tx", 192'(bus.tx), 192'(1));
    chk("reset_busy", 192'(bus.busy), 192'(0));
    chk("reset_overrun", 192'(bus.overrun), 192'(0));
    reset = 1'b0;
    @(negedge clock);

    // Basic line
    send_line(8'h12, 16'hBEEF, 16'h0000, 16'h00FF, 16'hA5A5, k);
    check_line("basic", k, model_line(8'h12, 16'hBEEF, 16'h0000, 16'h00FF, 16'hA5A5));
    chk("basic_overrun", 192'(bus.overrun), 192'(0));

    // Inputs changing after acceptance do not leak into the line
    send_line(8'h34, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333, k);
    bus.r0 = 16'h1234;
    bus.pc = 8'hFF;
    check_line("snapshot", k, model_line(8'h34, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333));

    // Triggers mid-line and on the last busy cycle are dropped
    pc = 8'($urandom); a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    send_line(pc, a, b, c, d, k);
    wait_until(k + 500);
    bus.pc = ~pc;
    bus.r0 = ~a;
    pulse_trigger();
    wait_until(k + LINE_CY);
    pulse_trigger();
    check_line("drop", k, model_line(pc, a, b, c, d));
    chk("drop_overrun", 192'(bus.overrun), 192'(1));
    wait_until(k + 1200);
    zeros = 0;
    ones  = 0;
    for (int i = k + LINE_CY + 1; i < k + 1198; i++) begin
      if (tx_log[i] !== 1'b1) zeros++;
      if (busy_log[i] !== 1'b0) ones++;
    end
    chk("drop_idle_tx", 192'(zeros), 192'(0));
    chk("drop_idle_busy", 192'(ones), 192'(0));

    // Trigger on the cycle after busy falls is accepted
    do_reset();
    pc = 8'($urandom); a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    send_line(pc, a, b, c, d, k);
    wait_until(k + LINE_CY + 1);
    chk("b2b_busy_low", 192'(bus.busy), 192'(0));
    send_line(~pc, ~a, ~b, ~c, ~d, k2);
    check_line("b2b_first", k, model_line(pc, a, b, c, d));
    check_line("b2b_second", k2, model_line(~pc, ~a, ~b, ~c, ~d));
    chk("b2b_overrun", 192'(bus.overrun), 192'(0));

    // Reset mid-byte aborts the line and clears overrun
    pc = 8'($urandom); a = 16'($urandom);
    send_line(pc, a, 16'h5A5A, 16'hFFFF, 16'h0001, k);
    wait_until(k + 100);
    pulse_trigger();
    chk("abort_overrun_set", 192'(bus.overrun), 192'(1));
    wait_until(k + 300);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_tx", 192'(bus.tx), 192'(1));
    chk("abort_busy", 192'(bus.busy), 192'(0));
    chk("abort_overrun", 192'(bus.overrun), 192'(0));
    reset = 1'b0;
    wait_until(k + 700);
    zeros = 0;
    ones  = 0;
    for (int i = k + 302; i < k + 698; i++) begin
      if (tx_log[i] !== 1'b1) zeros++;
      if (busy_log[i] !== 1'b0) ones++;
    end
    chk("abort_quiet_tx", 192'(zeros), 192'(0));
    chk("abort_quiet_busy", 192'(ones), 192'(0));

    // Trigger coincident with reset is ignored
    reset       = 1'b1;
    bus.trigger = 1'b1;
    @(negedge clock);
    reset       = 1'b0;
    bus.trigger = 1'b0;
    chk("rst_trig_busy", 192'(bus.busy), 192'(0));
    repeat (50) @(negedge clock);
    chk("rst_trig_tx", 192'(bus.tx), 192'(1));
    chk("rst_trig_busy_late", 192'(bus.busy), 192'(0));

    // First byte waveform for PC=0xA0: 'A' = 0x41
    a = 16'($urandom); b = 16'($urandom);
    send_line(8'hA0, a, b, 16'h0F0F, 16'hC3C3, k);
    wait_until(k + 50);
    frame_a = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 40; i++) begin
      wave_obs[39 - i] = tx_log[k + 1 + i];
      wave_exp[39 - i] = frame_a[i / CPB];
    end
    chk("wave_A", 192'(wave_obs), 192'(wave_exp));
    check_line("wave_line", k, model_line(8'hA0, a, b, 16'h0F0F, 16'hC3C3));

    // Randomized lines with input churn after acceptance
    for (int n = 0; n < 4; n++) begin
      pc = 8'($urandom); a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clock);
      send_line(pc, a, b, c, d, k);
      bus.pc = 8'($urandom);
      bus.r1 = 16'($urandom);
      bus.r3 = 16'($urandom);
      check_line($sformatf("rand%0d", n), k, model_line(pc, a, b, c, d));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_uart.md
TRACE_UART -- requirements
Module: trace_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clock cycles per UART bit (12 MHz / 115200); legal range 2..65535.
REQ-002 clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 trigger  in  1  single-cycle request to emit one trace line.
REQ-005 PC  in  8  CPU program counter, sampled on accepted trigger.
REQ-006 R0, R1, R2, R3  in  16 each  CPU registers, sampled on accepted trigger.
REQ-007 tx  out  1  UART transmit line, 8N1, idle high.
REQ-008 busy  out  1  high while a trace line is in flight.
REQ-009 overrun  out  1  sticky; set when a trigger is dropped.

Function
REQ-010 Trigger is accepted only when busy is low; on acceptance, PC and R0..R3 SHALL be latched into a snapshot register in the same edge, and later input changes SHALL NOT affect the line.
REQ-011 busy SHALL rise on the edge that accepts the trigger and fall on the edge that ends the final stop bit.
REQ-012 A trigger while busy is high, including on the final stop-bit cycle, SHALL be dropped and set overrun, which stays high until reset.
REQ-013 Line format, 24 bytes: PC as 2 hex digits, then for each of R0..R3 a space (0x20) and 4 hex digits, then CR (0x0D) and LF (0x0A).
REQ-014 Hex digits SHALL be uppercase ASCII: 0-9 map to 0x30-0x39 and A-F to 0x41-0x46; most-significant nibble is sent first.
REQ-015 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB-first, and 1 stop bit (1), each bit exactly CLKS_PER_BIT cycles; bytes are back-to-back with no idle gap.
REQ-016 The start bit of byte 0 SHALL appear on tx on the cycle after trigger acceptance; the total line lasts exactly 240*CLKS_PER_BIT cycles.
REQ-017 The sequencer FSM SHALL have states IDLE (wait for trigger), LOAD (select the next character by a 5-bit index 0..23), SEND (wait for byte done), and advance to IDLE after index 23.
REQ-018 The character index SHALL NOT wrap; reaching 23 followed by byte completion ends the line.
REQ-019 The bit counter and baud counter SHALL be sized from CLKS_PER_BIT without truncation.

Reset
REQ-020 Reset SHALL force tx=1, busy=0, overrun=0, FSM to IDLE, and all counters and indices to 0.
REQ-021 Reset mid-line SHALL abort immediately; tx SHALL be 1 the cycle after reset, and no partial byte resumes afterwards.
REQ-022 A trigger asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-023 A shared package trace_pkg SHALL hold the ASCII constants (SPACE, CR, LF, hex base values), LINE_LEN=24, and the FSM state enum.
REQ-024 A sub-module uart_tx SHALL serialize one byte using a valid/ready handshake; it is parameterised by CLKS_PER_BIT, and a byte is taken when valid and ready are both high.
REQ-025 trace_uart SHALL contain the snapshot register, nibble-to-ASCII mux, sequencer, and overrun logic.
REQ-026 trace_uart SHALL sit downstream of the CPU core in the top level; trigger is driven from the debounced step edge or from halt rising.

Verification (CLKS_PER_BIT=4 in simulation)
REQ-027 PC=0x12, R0=0xBEEF, R1=0x0000, R2=0x00FF, R3=0xA5A5, trigger -> the UART monitor decodes "12 BEEF 0000 00FF A5A5\r\n", and busy is high for exactly 960 cycles.
REQ-028 Trigger, then change R0 to 0x1234 on the next cycle -> the line still shows BEEF.
REQ-029 Second trigger at cycle 500 and a third at the last busy cycle -> both are dropped, overrun=1, and exactly one line is emitted.
REQ-030 A trigger on the cycle after busy falls -> accepted, and the second line's start bit follows with no stop-bit overlap.
REQ-031 Reset asserted at cycle 300 mid-byte -> tx=1, busy=0, and overrun=0 the next cycle; no further transitions occur until a new trigger.
REQ-032 Check the first byte for PC=0xA0 -> tx waveform is 0, then 1,0,0,0,0,0,1,0 (0x41 'A' LSB-first), then 1, each bit 4 cycles.
